// File: rtl/uart_pkg.sv
// Shared UART timing helpers and the TX arbiter state encoding.
package uart_pkg;

  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_GAP       = 2'd3
  } arb_state_t;

  // System clocks per UART bit (integer divide).
  function automatic int unsigned bit_cycles(input int unsigned clock_rate,
                                             input int unsigned baud);
    return clock_rate / baud;
  endfunction

  // Idle clocks inserted after each frame.
  function automatic int unsigned gap_cycles(input int unsigned gap_bits,
                                             input int unsigned bit_cyc);
    return gap_bits * bit_cyc;
  endfunction

  // Width of a requester index; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Width of a down-counter that starts at n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester side and transmitter side handshake bundle of the TX arbiter.
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
);

  localparam int unsigned IDW = idx_width(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [DATA_W*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ack;
  logic                      tx_start;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_busy;
  logic                      tx_done;
  logic [IDW-1:0]            grant_id;
  logic                      busy;

  // Arbiter view.
  modport slave (
    input  req_valid, req_data, tx_busy, tx_done,
    output req_ack, tx_start, tx_data, grant_id, busy
  );

  // Requester/transmitter environment view.
  modport master (
    output req_valid, req_data, tx_busy, tx_done,
    input  req_ack, tx_start, tx_data, grant_id, busy
  );

endinterface

// File: rtl/rr_select.sv
// Rotate-priority encoder: first set request at or after ptr, wrapping.
module rr_select
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IDW = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [IDW-1:0]     grant,
  output logic               any_valid
);

  int unsigned idx;

  // Scan offsets high to low so the smallest offset from ptr wins.
  always_comb begin
    grant     = '0;
    any_valid = |req;
    idx       = 0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      idx = 32'(ptr) + 32'(i);
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (req[IDW'(idx)]) begin
        grant = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sequencer sharing one 8N1 UART transmitter among NUM_REQ requesters.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_RATE = 100000000,
  parameter int unsigned BAUD_HEDEF = 115200,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned GAP_BITS   = 2
) (
  input logic              clk,
  input logic              rst,
  uart_tx_arbiter_if.slave bus
);

  localparam int unsigned IDW      = idx_width(NUM_REQ);
  localparam int unsigned BIT_CYC  = bit_cycles(CLOCK_RATE, BAUD_HEDEF);
  localparam int unsigned GAP_CYC  = gap_cycles(GAP_BITS, BIT_CYC);
  localparam int unsigned GAP_W    = cnt_width(GAP_CYC);
  localparam int unsigned GAP_LAST = (GAP_CYC == 0) ? 0 : GAP_CYC - 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_LAST);

  arb_state_t         state, state_nxt;
  logic [IDW-1:0]     rr_ptr, rr_ptr_nxt;
  logic [IDW-1:0]     grant_q, grant_nxt;
  logic [DATA_W-1:0]  tx_data_q, tx_data_nxt;
  logic [GAP_W-1:0]   gap_cnt, gap_nxt;
  logic [NUM_REQ-1:0] req_ack_q, req_ack_nxt;
  logic               tx_start_q, tx_start_nxt;
  logic               busy_q;

  logic [IDW-1:0]     sel_idx;
  logic               sel_any;

  rr_select #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_select (
    .req       (bus.req_valid),
    .ptr       (rr_ptr),
    .grant     (sel_idx),
    .any_valid (sel_any)
  );

  // Next-state and registered-output decode.
  always_comb begin
    state_nxt    = state;
    rr_ptr_nxt   = rr_ptr;
    grant_nxt    = grant_q;
    tx_data_nxt  = tx_data_q;
    gap_nxt      = gap_cnt;
    req_ack_nxt  = '0;
    tx_start_nxt = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (sel_any && !bus.tx_busy) begin
          state_nxt    = ST_START;
          grant_nxt    = sel_idx;
          tx_data_nxt  = bus.req_data[{sel_idx, 3'b000} +: DATA_W];
          tx_start_nxt = 1'b1;
        end
      end
      ST_START: begin
        state_nxt = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (bus.tx_done) begin
          req_ack_nxt = NUM_REQ'(1) << grant_q;
          rr_ptr_nxt  = (32'(grant_q) == NUM_REQ - 1) ? '0 : grant_q + IDW'(1);
          if (GAP_CYC > 0) begin
            state_nxt = ST_GAP;
            gap_nxt   = GAP_LOAD;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt == '0) begin
          state_nxt = ST_IDLE;
        end else begin
          gap_nxt = gap_cnt - GAP_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      rr_ptr     <= '0;
      grant_q    <= '0;
      tx_data_q  <= '0;
      gap_cnt    <= '0;
      req_ack_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      rr_ptr     <= rr_ptr_nxt;
      grant_q    <= grant_nxt;
      tx_data_q  <= tx_data_nxt;
      gap_cnt    <= gap_nxt;
      req_ack_q  <= req_ack_nxt;
      tx_start_q <= tx_start_nxt;
      busy_q     <= (state_nxt != ST_IDLE);
    end
  end

  assign bus.req_ack  = req_ack_q;
  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.grant_id = grant_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: default build plus a GAP_BITS=0 build.
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(4)) a_if ();
  uart_tx_arbiter_if #(.NUM_REQ(4)) b_if ();

  uart_tx_arbiter #(
    .CLOCK_RATE (100000000),
    .BAUD_HEDEF (115200),
    .NUM_REQ    (4),
    .GAP_BITS   (2)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (a_if)
  );

  uart_tx_arbiter #(
    .CLOCK_RATE (100000000),
    .BAUD_HEDEF (115200),
    .NUM_REQ    (4),
    .GAP_BITS   (0)
  ) u_dut_nogap (
    .clk (clk),
    .rst (rst),
    .bus (b_if)
  );

  int unsigned total  = 0;
  int unsigned passed = 0;
  int unsigned failed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One full frame on the default build, starting from IDLE with a request pending.
  task automatic serve(input string tag, input int unsigned g, input logic [7:0] d,
                       input bit drop, input logic [3:0] clr_mask);
    int unsigned n;
    step(1);
    chk({tag, ".start"}, 32'(a_if.tx_start), 32'd1);
    chk({tag, ".grant"}, 32'(a_if.grant_id), g);
    chk({tag, ".data"},  32'(a_if.tx_data), 32'(d));
    chk({tag, ".busy"},  32'(a_if.busy), 32'd1);
    step(1);
    chk({tag, ".start_1cyc"}, 32'(a_if.tx_start), 32'd0);
    if (drop) begin
      a_if.req_valid[g] = 1'b0;
      a_if.req_data     = '0;
    end
    a_if.tx_busy = 1'b1;
    step(3);
    chk({tag, ".hold"}, 32'(a_if.tx_data), 32'(d));
    a_if.tx_done = 1'b1;
    a_if.tx_busy = 1'b0;
    step(1);
    a_if.tx_done   = 1'b0;
    a_if.req_valid = a_if.req_valid & ~clr_mask;
    chk({tag, ".ack"}, 32'(a_if.req_ack), 32'(4'b0001 << g));
    chk({tag, ".ack_nostart"}, 32'(a_if.tx_start), 32'd0);
    step(1);
    n = 1;
    chk({tag, ".ack_pulse"}, 32'(a_if.req_ack), 32'd0);
    while (a_if.busy === 1'b1 && n < 3000) begin
      step(1);
      n++;
    end
    chk({tag, ".gap_len"}, n, 32'd1736);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned seen;
    a_if.req_valid = '0; a_if.req_data = '0; a_if.tx_busy = 1'b0; a_if.tx_done = 1'b0;
    b_if.req_valid = '0; b_if.req_data = '0; b_if.tx_busy = 1'b0; b_if.tx_done = 1'b0;
    rst = 1'b1;
    step(2);
    chk("rst.ack",   32'(a_if.req_ack),  32'd0);
    chk("rst.start", 32'(a_if.tx_start), 32'd0);
    chk("rst.data",  32'(a_if.tx_data),  32'd0);
    chk("rst.grant", 32'(a_if.grant_id), 32'd0);
    chk("rst.busy",  32'(a_if.busy),     32'd0);
    rst = 1'b0;
    step(1);
    chk("idle.busy", 32'(a_if.busy), 32'd0);

    // Single request from requester 1.
    a_if.req_data  = 32'h3344_A566;
    a_if.req_valid = 4'b0010;
    serve("single", 1, 8'hA5, 1'b0, 4'b0010);

    // Round robin with all four pending; restart pointer from 0.
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    a_if.req_data  = 32'h1312_1110;
    a_if.req_valid = 4'b1111;
    serve("rr0", 0, 8'h10, 1'b0, 4'b0000);
    serve("rr1", 1, 8'h11, 1'b0, 4'b0000);
    serve("rr2", 2, 8'h12, 1'b0, 4'b0000);
    serve("rr3", 3, 8'h13, 1'b0, 4'b0000);
    serve("rr4", 0, 8'h10, 1'b0, 4'b1111);

    // Requester 2 drops valid right after its grant.
    a_if.req_data  = 32'h005C_0000;
    a_if.req_valid = 4'b0100;
    serve("drop", 2, 8'h5C, 1'b1, 4'b0000);

    // Transmitter busy blocks launch for 100 cycles.
    a_if.tx_busy   = 1'b1;
    a_if.req_data  = 32'h0000_0077;
    a_if.req_valid = 4'b0001;
    seen = 0;
    repeat (100) begin
      step(1);
      if (a_if.tx_start === 1'b1) seen++;
    end
    chk("blk.nostart", seen, 32'd0);
    chk("blk.idle", 32'(a_if.busy), 32'd0);
    a_if.tx_busy = 1'b0;
    serve("blk", 0, 8'h77, 1'b0, 4'b0001);

    // Reset while waiting for tx_done on requester 3.
    a_if.req_data  = 32'h3C00_0000;
    a_if.req_valid = 4'b1000;
    step(1);
    chk("mid.start", 32'(a_if.tx_start), 32'd1);
    chk("mid.grant", 32'(a_if.grant_id), 32'd3);
    step(1);
    a_if.tx_busy = 1'b1;
    step(2);
    rst = 1'b1;
    a_if.req_valid = '0;
    step(1);
    chk("mid.rst_ack",   32'(a_if.req_ack),  32'd0);
    chk("mid.rst_start", 32'(a_if.tx_start), 32'd0);
    chk("mid.rst_data",  32'(a_if.tx_data),  32'd0);
    chk("mid.rst_grant", 32'(a_if.grant_id), 32'd0);
    chk("mid.rst_busy",  32'(a_if.busy),     32'd0);
    rst = 1'b0;
    a_if.tx_done = 1'b1;
    step(1);
    a_if.tx_done = 1'b0;
    a_if.tx_busy = 1'b0;
    chk("mid.stray_ack",  32'(a_if.req_ack), 32'd0);
    chk("mid.stray_busy", 32'(a_if.busy),    32'd0);
    step(1);
    chk("mid.no_late_ack", 32'(a_if.req_ack), 32'd0);
    a_if.req_data  = 32'h3C00_00E1;
    a_if.req_valid = 4'b1001;
    serve("post", 0, 8'hE1, 1'b0, 4'b1001);

    // GAP_BITS=0 build: back-to-back frames.
    b_if.req_data  = 32'h0000_2221;
    b_if.req_valid = 4'b0011;
    step(1);
    chk("ng.start0", 32'(b_if.tx_start), 32'd1);
    chk("ng.grant0", 32'(b_if.grant_id), 32'd0);
    chk("ng.data0",  32'(b_if.tx_data),  32'h21);
    step(1);
    b_if.tx_busy = 1'b1;
    step(2);
    b_if.tx_done = 1'b1;
    b_if.tx_busy = 1'b0;
    step(1);
    b_if.tx_done   = 1'b0;
    b_if.req_valid = 4'b0010;
    chk("ng.ack0",   32'(b_if.req_ack),  32'b0001);
    chk("ng.busy0",  32'(b_if.busy),     32'd0);
    chk("ng.nostart", 32'(b_if.tx_start), 32'd0);
    step(1);
    chk("ng.start1", 32'(b_if.tx_start), 32'd1);
    chk("ng.grant1", 32'(b_if.grant_id), 32'd1);
    chk("ng.data1",  32'(b_if.tx_data),  32'h22);
    step(1);
    b_if.tx_done = 1'b1;
    step(1);
    b_if.tx_done   = 1'b0;
    b_if.req_valid = '0;
    chk("ng.ack1", 32'(b_if.req_ack), 32'b0010);
    step(1);
    chk("ng.idle", 32'(b_if.busy), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
